// File: rtl/ram_mover_pkg.sv
// Shared definitions for the RAM block mover: opcode encodings, FSM states and
// default geometry of the 256x64 data RAM.
package ram_mover_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 64;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StFillw,
    StDone
  } state_e;

endpackage

// File: rtl/ram_block_mover.sv
// Command-driven COPY/FILL engine that masters the single-port RAM while busy.
// All outputs are registered and are computed from the next state.
module ram_block_mover
  import ram_mover_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  logic              ready_d, busy_d, done_d, write_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] wdata_d;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    ready_d   = cmd_ready;
    busy_d    = busy;
    done_d    = 1'b0;
    write_d   = 1'b0;
    address_d = mem_address;
    wdata_d   = mem_wdata;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          if (cmd_op == OP_FILL) begin
            // mem_wdata keeps the pattern for the whole fill
            state_d   = StFillw;
            address_d = cmd_dst;
            wdata_d   = cmd_fill;
            write_d   = 1'b1;
          end else begin
            state_d   = StRd;
            src_d     = cmd_src;
            address_d = cmd_src;
          end
        end
      end

      StRd: begin
        // RAM sampled the address on the mid-cycle negedge; data is valid now
        state_d   = StWr;
        address_d = dst_q;
        wdata_d   = mem_rdata;
        write_d   = 1'b1;
      end

      StWr: begin
        if (rem_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = StRd;
          src_d     = src_q + ADDR_W'(1);
          dst_d     = dst_q + ADDR_W'(1);
          rem_d     = rem_q - ADDR_W'(1);
          address_d = src_q + ADDR_W'(1);
        end
      end

      StFillw: begin
        if (rem_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          dst_d     = dst_q + ADDR_W'(1);
          rem_d     = rem_q - ADDR_W'(1);
          address_d = dst_q + ADDR_W'(1);
          write_d   = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      cmd_ready   <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
      mem_write   <= write_d;
      mem_address <= address_d;
      mem_wdata   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural 256x64 RAM target, table vectors,
// hand-written corner sequences and random commands against an array model.
module tb_ram_block_mover;
  import ram_mover_pkg::*;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst, cmd_len;
  logic [DW-1:0] cmd_fill;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ram_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_fill   (cmd_fill),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  // Target RAM: synchronous read and write on the negedge
  logic [DW-1:0] ram      [256];
  logic [DW-1:0] ram_init [256];
  logic          load = 1'b0;
  wr_t           wlog[$];

  always @(negedge clock) begin
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
    end else begin
      if (mem_write) begin
        ram[mem_address] <= mem_wdata;
        wlog.push_back({mem_address, mem_wdata});
      end
      mem_rdata <= ram[mem_address];
    end
  end

  logic [DW-1:0] model_mem [256];
  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic preload(input bit ramp);
    for (int i = 0; i < 256; i++) begin
      ram_init[i]  = ramp ? 64'(i) : {$urandom, $urandom};
      model_mem[i] = ram_init[i];
    end
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  task automatic compare_ram(input string nm);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== model_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0)
      $display("FAIL %s: %0d RAM words differ, first at %0h got %0h expected %0h", nm, bad,
               first, ram[first], model_mem[first]);
    total++;
    if (bad == 0) passed++;
  endtask

  // Issue one command, model it, and check timing, write trace, reads and RAM.
  task automatic run_cmd(input string nm, input logic op, input logic [7:0] src,
                         input logic [7:0] dst, input logic [7:0] len, input logic [63:0] fill,
                         input int intrude, output int lat, output int nwr);
    wr_t        exp_w[$];
    logic [7:0] exp_r[$];
    logic [7:0] got_r[$];
    int         exp_lat;
    int         bad;
    for (int i = 0; i <= int'(len); i++) begin
      logic [7:0]  d, s;
      logic [63:0] v;
      d = dst + 8'(i);
      s = src + 8'(i);
      v = (op == OP_FILL) ? fill : model_mem[s];
      if (op == OP_COPY) exp_r.push_back(s);
      model_mem[d] = v;
      exp_w.push_back({d, v});
    end
    exp_lat = (op == OP_FILL) ? int'(len) + 1 : 2 * (int'(len) + 1);

    wlog.delete();
    check({nm, " ready_before"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_fill = fill;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check({nm, " first_addr"}, 64'(mem_address), 64'((op == OP_FILL) ? dst : src));
    check({nm, " ready_busy"}, 64'({busy, cmd_ready}), 64'(2'b10));

    bad = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 700) begin
      if (busy !== 1'b1 || mem_write !== ((op == OP_FILL) || (lat % 2 == 1))) bad++;
      if (busy === 1'b1 && mem_write === 1'b0) got_r.push_back(mem_address);
      if (lat == intrude) begin
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 8'hEE; cmd_len = 8'h00;
        cmd_fill = 64'hBAD;
      end
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " write_pattern_errs"}, 64'(bad), 64'(0));
    check({nm, " done_cycle"}, 64'({done, busy, mem_write, cmd_ready}), 64'(4'b1000));
    @(posedge clock); #1;
    check({nm, " after_done"}, 64'({done, busy, cmd_ready}), 64'(3'b001));

    nwr = wlog.size();
    bad = (wlog.size() != exp_w.size()) ? 1 : 0;
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
      if (wlog[i] !== exp_w[i]) bad++;
    check({nm, " write_trace_errs"}, 64'(bad), 64'(0));
    bad = (got_r.size() != exp_r.size()) ? 1 : 0;
    for (int i = 0; i < got_r.size() && i < exp_r.size(); i++)
      if (got_r[i] !== exp_r[i]) bad++;
    check({nm, " read_order_errs"}, 64'(bad), 64'(0));
    compare_ram({nm, " ram"});
  endtask

  typedef struct {
    bit          pre;
    logic        op;
    logic [7:0]  src, dst, len;
    logic [63:0] fill;
    int          exp_lat;
    int          exp_wr;
    logic [7:0]  chk_a;
    logic [63:0] chk_v;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, nwr;
    vecs[0] = '{1'b1, OP_FILL, 8'h00, 8'h10, 8'd3, 64'hDEADBEEF_00000001, 4, 4, 8'h14, 64'h14};
    vecs[1] = '{1'b1, OP_COPY, 8'h20, 8'h80, 8'd7, 64'h0, 16, 8, 8'h87, 64'h27};
    vecs[2] = '{1'b1, OP_COPY, 8'hFE, 8'h01, 8'd3, 64'h0, 8, 4, 8'h04, 64'hFE};
    vecs[3] = '{1'b1, OP_COPY, 8'h11, 8'h10, 8'd3, 64'h0, 8, 4, 8'h13, 64'h14};
    vecs[4] = '{1'b0, OP_FILL, 8'h00, 8'h00, 8'hFF, 64'hA5A5A5A5_A5A5A5A5, 256, 256, 8'hFF,
                64'hA5A5A5A5_A5A5A5A5};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_fill = '0;
    #1;
    check("reset_ctrl", 64'({cmd_ready, busy, done, mem_write}), 64'(4'b1000));
    check("reset_addr", 64'(mem_address), 64'(0));
    check("reset_wdata", mem_wdata, 64'(0));
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      if (vecs[k].pre) preload(1'b1);
      run_cmd(nm, vecs[k].op, vecs[k].src, vecs[k].dst, vecs[k].len, vecs[k].fill, -1,
              lat, nwr);
      check({nm, " tbl_latency"}, 64'(lat), 64'(vecs[k].exp_lat));
      check({nm, " tbl_writes"}, 64'(nwr), 64'(vecs[k].exp_wr));
      check({nm, " tbl_word"}, ram[vecs[k].chk_a], vecs[k].chk_v);
    end

    // cmd_valid held high across a one-word FILL: exactly one accept
    wlog.delete();
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_dst = 8'h30; cmd_len = 8'h00;
    cmd_fill = 64'h0123_4567_89AB_CDEF;
    @(posedge clock); #1;
    check("hold_accept", 64'({busy, cmd_ready, mem_write}), 64'(3'b101));
    cmd_dst = 8'h31;
    @(posedge clock); #1;
    check("hold_done", 64'({done, busy, cmd_ready, mem_write}), 64'(4'b1000));
    @(posedge clock); #1;
    check("hold_ready", 64'({done, busy, cmd_ready}), 64'(3'b001));
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("hold_no_reaccept", 64'(busy), 64'(0));
    check("hold_one_write", 64'(wlog.size()), 64'(1));
    model_mem[8'h30] = 64'h0123_4567_89AB_CDEF;

    // A command pulsed mid-fill must be dropped
    run_cmd("intrude", OP_FILL, 8'h00, 8'h50, 8'd5, 64'h5555_0000_AAAA_FFFF, 2, lat, nwr);

    // Reset during the write of word 2 of an 8-word copy
    preload(1'b1);
    wlog.delete();
    cmd_valid = 1'b1; cmd_op = OP_COPY; cmd_src = 8'h40; cmd_dst = 8'hC0; cmd_len = 8'd7;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    check("abort_in_wr", 64'({mem_write, mem_address}), 64'({1'b1, 8'hC2}));
    reset = 1'b1;
    #1;
    check("abort_async", 64'({mem_write, busy, cmd_ready, done}), 64'(4'b0010));
    @(posedge clock); #1;
    reset = 1'b0;
    begin
      int seen_done = 0;
      repeat (20) begin
        @(posedge clock); #1;
        if (done === 1'b1) seen_done++;
      end
      check("abort_no_done", 64'(seen_done), 64'(0));
    end
    check("abort_writes", 64'(wlog.size()), 64'(2));
    check("abort_w0", ram[8'hC0], 64'h40);
    check("abort_w1", ram[8'hC1], 64'h41);
    check("abort_w2", ram[8'hC2], 64'hC2);
    model_mem[8'hC0] = 64'h40;
    model_mem[8'hC1] = 64'h41;

    // Random commands against the array model
    preload(1'b0);
    for (int n = 0; n < 25; n++) begin
      logic        op;
      logic [7:0]  s, d, l;
      logic [63:0] f;
      op = 1'($urandom);
      s  = 8'($urandom);
      d  = 8'($urandom);
      l  = 8'($urandom_range(0, 24));
      f  = {$urandom, $urandom};
      run_cmd($sformatf("rand%0d", n), op, s, d, l, f, -1, lat, nwr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
